// File: rtl/seq_det_pkg.sv
// Shared types, default sizes and the pattern-length clamp for the serial sequence detector.
package seq_det_pkg;

    localparam int unsigned PAT_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } seq_det_state_t;

    // Out-of-range lengths fold onto the nearest legal value: 0 -> 1, >max -> max.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register, fill counter and EMPTY/FILLING/ARMED tracking for seq_det_param.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic                 i_x,
    input  logic                 i_flush,
    input  logic                 i_clr_match,
    input  logic [LEN_W-1:0]     i_len,
    output logic [LEN_W-1:0]     o_fill,
    output logic [PAT_W-1:0]     o_hist_nxt,
    output logic [LEN_W-1:0]     o_fill_nxt,
    output seq_det_state_t       o_state
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    seq_det_state_t   r_state;

    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;

    assign w_hist_nxt = {r_hist[PAT_W-2:0], i_x};
    assign w_fill_nxt = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + LEN_W'(1);

    // Flush wins over everything; a non-overlapping match restarts collection from scratch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= EMPTY;
        end else if (i_flush) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= EMPTY;
        end else if (i_valid) begin
            if (i_clr_match) begin
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= EMPTY;
            end else begin
                r_hist  <= w_hist_nxt;
                r_fill  <= w_fill_nxt;
                r_state <= (w_fill_nxt >= i_len) ? ARMED : FILLING;
            end
        end
    end

    assign o_fill     = r_fill;
    assign o_hist_nxt = w_hist_nxt;
    assign o_fill_nxt = w_fill_nxt;
    assign o_state    = r_state;

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector with registered Mealy match pulse.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1),
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             y,
    output logic [LEN_W-1:0] fill,
    output logic [CNT_W-1:0] match_cnt
);

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic             r_y;

    logic [LEN_W-1:0] w_len_clamped;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0] w_mask;
    seq_det_state_t   w_state;
    logic             w_len_ok;
    logic             w_bits_eq;
    logic             w_match;

    assign w_len_clamped = LEN_W'(clamp_len(32'(cfg_len), PAT_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat     <= '0;
            r_len     <= LEN_W'(PAT_W);
            r_overlap <= 1'b1;
        end else if (cfg_load) begin
            r_pat     <= cfg_pat;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
        end
    end

    seq_det_hist #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (in_valid),
        .i_x         (x),
        .i_flush     (cfg_load),
        .i_clr_match (w_match & ~r_overlap),
        .i_len       (r_len),
        .o_fill      (fill),
        .o_hist_nxt  (w_hist_nxt),
        .o_fill_nxt  (w_fill_nxt),
        .o_state     (w_state)
    );

    // Only the low len bits of the candidate history take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < 32'(r_len));
        end
    end

    assign w_bits_eq = (((w_hist_nxt ^ r_pat) & w_mask) == '0);
    assign w_len_ok  = (w_state == ARMED) || (w_fill_nxt >= r_len);
    assign w_match   = !cfg_load && in_valid && w_len_ok && w_bits_eq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_match;
        end
    end

    assign y = r_y;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: driver queues hand-computed expectations, monitor checks them.
module tb_seq_det_param;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             x;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             y;
    logic [LEN_W-1:0] fill;
    logic [CNT_W-1:0] match_cnt;

    typedef struct {
        logic  ey;
        int    efill;
        int    ecnt;
        string name;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cnt_m  = 0;

    seq_det_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pat     (cfg_pat),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .y           (y),
        .fill        (fill),
        .match_cnt   (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int exp_cnt_now();
`ifdef SEQ_DET_MATCH_CNT_EN
        return cnt_m;
`else
        return 0;
`endif
    endfunction

    task automatic push(input logic ey, input int ef, input string nm);
        exp_t e;
        if (ey) cnt_m = (cnt_m == 15) ? 15 : cnt_m + 1;
        e.ey    = ey;
        e.efill = ef;
        e.ecnt  = exp_cnt_now();
        e.name  = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic v, input logic xb, input logic ey, input int ef, input string nm);
        @(negedge clk);
        in_valid = v;
        x        = xb;
        cfg_load = 1'b0;
        push(ey, ef, nm);
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov,
                       input logic v, input logic xb, input string nm);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pat     = p;
        cfg_len     = l;
        cfg_overlap = ov;
        in_valid    = v;
        x           = xb;
        push(1'b0, 0, nm);
    endtask

    // Monitor: every clock after the driver has queued a vector, compare the DUT response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".y"},    32'(y),         32'(e.ey));
                chk({e.name, ".fill"}, 32'(fill),      32'(e.efill));
                chk({e.name, ".cnt"},  32'(match_cnt), 32'(e.ecnt));
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x = 1'b0; cfg_load = 1'b0;
        cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset.y",    32'(y),         0);
        chk("reset.fill", 32'(fill),      0);
        chk("reset.cnt",  32'(match_cnt), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single match, overlap on
        cfg(8'h04, 4'd4, 1'b1, 1'b0, 1'b0, "t1.cfg");
        step(1, 0, 0, 1, "t1.b1"); step(1, 1, 0, 2, "t1.b2");
        step(1, 0, 0, 3, "t1.b3"); step(1, 0, 1, 4, "t1.b4");
        step(0, 0, 0, 4, "t1.idle");

        // Overlapping stream 0100100
        cfg(8'h04, 4'd4, 1'b1, 1'b0, 1'b0, "t2.cfg");
        step(1, 0, 0, 1, "t2.b1"); step(1, 1, 0, 2, "t2.b2");
        step(1, 0, 0, 3, "t2.b3"); step(1, 0, 1, 4, "t2.b4");
        step(1, 1, 0, 5, "t2.b5"); step(1, 0, 0, 6, "t2.b6");
        step(1, 0, 1, 7, "t2.b7");

        // Non-overlapping: history cleared after the first match
        cfg(8'h04, 4'd4, 1'b0, 1'b0, 1'b0, "t3.cfg");
        step(1, 0, 0, 1, "t3.b1"); step(1, 1, 0, 2, "t3.b2");
        step(1, 0, 0, 3, "t3.b3"); step(1, 0, 1, 0, "t3.b4");
        step(1, 1, 0, 1, "t3.b5"); step(1, 0, 0, 2, "t3.b6");
        step(1, 0, 0, 3, "t3.b7");

        // in_valid gap holds state and suppresses y
        cfg(8'h04, 4'd4, 1'b1, 1'b0, 1'b0, "t4.cfg");
        step(1, 0, 0, 1, "t4.b1"); step(1, 1, 0, 2, "t4.b2");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 2, "t4.gap");
        step(1, 0, 0, 3, "t4.b3"); step(1, 0, 1, 4, "t4.b4");

        // Reconfiguration flushes partial history and drops the bit on the load edge
        cfg(8'h04, 4'd4, 1'b1, 1'b0, 1'b0, "t5.cfg");
        step(1, 0, 0, 1, "t5.b1"); step(1, 1, 0, 2, "t5.b2");
        step(1, 0, 0, 3, "t5.b3");
        cfg(8'h03, 4'd2, 1'b1, 1'b1, 1'b1, "t5.recfg");
        step(1, 1, 0, 1, "t5.b4"); step(1, 1, 1, 2, "t5.b5");

        // Length clamps: 0 -> 1 and 15 -> 8
        cfg(8'h01, 4'd0, 1'b1, 1'b0, 1'b0, "t6.cfg");
        step(1, 1, 1, 1, "t6.b1"); step(1, 0, 0, 2, "t6.b2");
        step(1, 1, 1, 3, "t6.b3");
        cfg(8'hFF, 4'd15, 1'b1, 1'b0, 1'b0, "t7.cfg");
        for (int i = 1; i <= 7; i++) step(1, 1, 0, i, "t7.fill");
        step(1, 1, 1, 8, "t7.b8"); step(1, 1, 1, 8, "t7.b9");

        // Asynchronous reset right after a match pulse
        cfg(8'h04, 4'd4, 1'b1, 1'b0, 1'b0, "t8.cfg");
        step(1, 0, 0, 1, "t8.b1"); step(1, 1, 0, 2, "t8.b2");
        step(1, 0, 0, 3, "t8.b3"); step(1, 0, 1, 4, "t8.b4");
        @(posedge clk);
        #3;
        rst = 1'b0; in_valid = 1'b0; x = 1'b0;
        #1;
        chk("t8.rst.y",    32'(y),         0);
        chk("t8.rst.fill", 32'(fill),      0);
        chk("t8.rst.cnt",  32'(match_cnt), 0);
        cnt_m = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        // Reset config is pat=0, len=8: only the 8th zero matches
        for (int i = 1; i <= 7; i++) step(1, 0, 0, i, "t8.zero");
        step(1, 0, 1, 8, "t8.z8");

        // Counter saturation at 15
        cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, "t9.cfg");
        for (int i = 1; i <= 16; i++) step(1, 1, 1, (i > 8) ? 8 : i, "t9.sat");
        step(0, 0, 0, 8, "t9.idle");

        // Drain with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
